rv_inst_encoder: RTL and testbench
==================================

Name: rv_inst_encoder

Overview:
Inverse of the core's instruction decoder. Takes field-level instruction requests (kind, ALU op, registers, immediate) and emits legal RV32I 32-bit instruction words, each tagged with a sequential instruction address. Feeds the boot-ROM builder and the self-test program loader that write instruction memory. Valid/ready on both sides, one registered output stage.

Parameters:
BASE_ADDR, 32'h0000_0000, address tagged on the first word after reset or addr_clr.
ERR_W, 8, width of the saturating error counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_kind  in  4  0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 LUI, 5 AUIPC, 6 BRANCH, 7 JAL, 8 JALR, 9-15 illegal
req_alu_op  in  5  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 LUI=10; used for R and I-ALU only
req_funct3  in  3  funct3 for LOAD/STORE/BRANCH
req_rd, req_rs1, req_rs2  in  5 each  register indices
req_imm  in  32  immediate as a full signed byte value; U-type uses the upper value directly
addr_clr  in  1  reload the address counter with BASE_ADDR
inst_valid  out  1  output word valid
inst_ready  in  1  consumer accepts when inst_valid && inst_ready
inst_word  out  32  encoded instruction
inst_addr  out  32  address of inst_word
err_pulse  out  1  one-cycle pulse when an illegal request is dropped
err_count  out  ERR_W  saturating count of dropped requests

Behaviour:
- Reset: inst_valid=0, inst_word=0, inst_addr=BASE_ADDR, next address=BASE_ADDR, err_pulse=0, err_count=0. A request in flight during reset is lost.
- req_ready = !inst_valid || inst_ready. This gives full throughput with no bubble.
- Latency: a legal request accepted in cycle N presents inst_valid in cycle N+1. The output is held stable while inst_valid && !inst_ready.
- Legal accept: the output register captures the word and the next-address value. The next address then increments by 4, wrapping modulo 2^32.
- Illegal accept: the request is consumed but produces no output. err_pulse=1 in cycle N+1, err_count increments and saturates at all-ones, and the address does not advance.
- Encoding per kind:
  - R: opcode 0110011. funct3/funct7 from alu_op: ADD 000/00, SUB 000/20, SLL 001, SLT 010, SLTU 011, XOR 100, SRL 101/00, SRA 101/20, OR 110, AND 111 (funct7 in hex; 00 where not given). LUI op is illegal.
  - I-ALU: opcode 0010011, same funct3 mapping. SUB and LUI ops are illegal. SLL/SRL/SRA place imm[4:0] in shamt and funct7 in [31:25].
  - LOAD: opcode 0000011. funct3 must be one of {000,001,010,100,101}.
  - STORE: opcode 0100011, S-format. funct3 must be one of {000,001,010}.
  - BRANCH: opcode 1100011, B-format. funct3 must be one of {000,001,100,101,110,111}.
  - LUI: opcode 0110111. AUIPC: opcode 0010111. Both set word[31:12]=imm[31:12].
  - JAL: opcode 1101111, J-format.
  - JALR: opcode 1100111, funct3=000.
- Range rules:
  - I/S/JALR: imm fits signed 12 bits.
  - Shifts: imm[31:5]==0.
  - B: fits signed 13 bits and imm[0]=0.
  - J: fits signed 21 bits and imm[0]=0.
  - U: imm[11:0]=0.
- Unused fields (e.g. rs2 for I-type) are ignored.
- addr_clr: the next address becomes BASE_ADDR. If it coincides with a legal accept, the accepted word takes BASE_ADDR and the next address becomes BASE_ADDR+4. It does not change a word already held at the output.

Optional Feature:
ENC_RANGE_CHECK_EN:
- Defined: the immediate range/alignment rules above apply, and violations are dropped and counted.
- Undefined: immediates are silently truncated to their field width (low bits placed, alignment bit discarded). Only illegal kind, op and funct3 values count as errors.

Test Plan:
- R ADD rd=3 rs1=1 rs2=2, inst_ready=1 -> cycle N+1: inst_word=0x002081B3, inst_addr=0x0.
- I-ALU ADD rd=1 rs1=0 imm=-1, then SRA rd=5 rs1=5 imm=3, back-to-back -> 0xFFF00093 @0x0, then 0x4032D293 @0x4, no bubble.
- LUI rd=2 imm=0x12345000, then JAL rd=1 imm=8 -> 0x12345137 and 0x008000EF at consecutive addresses.
- BRANCH imm=3 with ENC_RANGE_CHECK_EN defined -> no inst_valid, err_pulse for one cycle, err_count=1, next legal word takes the unadvanced address. Repeat 300 times with ERR_W=8 -> err_count saturates at 255.
- Hold inst_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, inst_word/inst_addr stable. Release -> stream resumes in order with no lost or duplicated word.
- Assert addr_clr together with an accept at address 0x10; separately assert rst while inst_valid=1 -> accepted word tagged BASE_ADDR; after rst all outputs return to reset values.

Source files
------------

// File: rtl/rv_inst_encoder.sv
// Turns field-level instruction requests into RV32I words, each tagged with a sequential address.
// Define ENC_RANGE_CHECK_EN to drop and count requests whose immediates do not fit their field.
module rv_inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_kind,
  input  logic [4:0]       req_alu_op,
  input  logic [2:0]       req_funct3,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic [31:0]      req_imm,
  input  logic             addr_clr,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst_word,
  output logic [31:0]      inst_addr,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [3:0] K_R      = 4'd0;
  localparam logic [3:0] K_IALU   = 4'd1;
  localparam logic [3:0] K_LOAD   = 4'd2;
  localparam logic [3:0] K_STORE  = 4'd3;
  localparam logic [3:0] K_LUI    = 4'd4;
  localparam logic [3:0] K_AUIPC  = 4'd5;
  localparam logic [3:0] K_BRANCH = 4'd6;
  localparam logic [3:0] K_JAL    = 4'd7;
  localparam logic [3:0] K_JALR   = 4'd8;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_SLL  = 5'd2;
  localparam logic [4:0] OP_SLT  = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;

  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  logic        accept;
  logic [2:0]  alu_f3;
  logic [6:0]  alu_f7;
  logic        alu_ok;
  logic        is_shift;
  logic        fmt_ok;
  logic        imm_ok;
  logic        legal;
  logic [31:0] enc_word;
  logic [31:0] next_addr;
  logic [31:0] cur_addr;

  assign req_ready = !inst_valid || inst_ready;
  assign accept    = req_valid && req_ready;
  assign cur_addr  = addr_clr ? BASE_ADDR : next_addr;

  always_comb begin
    alu_f3 = 3'b000;
    alu_f7 = 7'h00;
    alu_ok = 1'b1;
    case (req_alu_op)
      OP_ADD:  alu_f3 = 3'b000;
      OP_SUB:  begin alu_f3 = 3'b000; alu_f7 = 7'h20; end
      OP_SLL:  alu_f3 = 3'b001;
      OP_SLT:  alu_f3 = 3'b010;
      OP_SLTU: alu_f3 = 3'b011;
      OP_XOR:  alu_f3 = 3'b100;
      OP_SRL:  alu_f3 = 3'b101;
      OP_SRA:  begin alu_f3 = 3'b101; alu_f7 = 7'h20; end
      OP_OR:   alu_f3 = 3'b110;
      OP_AND:  alu_f3 = 3'b111;
      default: alu_ok = 1'b0;   // includes the LUI op, which has no R/I-ALU form
    endcase
  end

  assign is_shift = (alu_f3 == 3'b001) || (alu_f3 == 3'b101);

  always_comb begin
    enc_word = 32'h0;
    fmt_ok   = 1'b0;
    case (req_kind)
      K_R: begin
        fmt_ok   = alu_ok;
        enc_word = {alu_f7, req_rs2, req_rs1, alu_f3, req_rd, 7'b0110011};
      end
      K_IALU: begin
        fmt_ok   = alu_ok && (req_alu_op != OP_SUB);
        enc_word = is_shift ? {alu_f7, req_imm[4:0], req_rs1, alu_f3, req_rd, 7'b0010011}
                            : {req_imm[11:0], req_rs1, alu_f3, req_rd, 7'b0010011};
      end
      K_LOAD: begin
        fmt_ok   = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) && (req_funct3 != 3'b111);
        enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, 7'b0000011};
      end
      K_STORE: begin
        fmt_ok   = (req_funct3 <= 3'b010);
        enc_word = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], 7'b0100011};
      end
      K_LUI: begin
        fmt_ok   = 1'b1;
        enc_word = {req_imm[31:12], req_rd, 7'b0110111};
      end
      K_AUIPC: begin
        fmt_ok   = 1'b1;
        enc_word = {req_imm[31:12], req_rd, 7'b0010111};
      end
      K_BRANCH: begin
        fmt_ok   = (req_funct3 != 3'b010) && (req_funct3 != 3'b011);
        enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                    req_imm[4:1], req_imm[11], 7'b1100011};
      end
      K_JAL: begin
        fmt_ok   = 1'b1;
        enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, 7'b1101111};
      end
      K_JALR: begin
        fmt_ok   = 1'b1;
        enc_word = {req_imm[11:0], req_rs1, 3'b000, req_rd, 7'b1100111};
      end
      default: fmt_ok = 1'b0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic fit12, fit13, fit21;

  assign fit12 = (req_imm[31:11] == {21{req_imm[11]}});
  assign fit13 = (req_imm[31:12] == {20{req_imm[12]}});
  assign fit21 = (req_imm[31:20] == {12{req_imm[20]}});

  always_comb begin
    imm_ok = 1'b1;
    case (req_kind)
      K_IALU:                  imm_ok = is_shift ? (req_imm[31:5] == 27'h0) : fit12;
      K_LOAD, K_STORE, K_JALR: imm_ok = fit12;
      K_BRANCH:                imm_ok = fit13 && !req_imm[0];
      K_JAL:                   imm_ok = fit21 && !req_imm[0];
      K_LUI, K_AUIPC:          imm_ok = (req_imm[11:0] == 12'h0);
      default:                 imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

  assign legal = fmt_ok && imm_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_valid <= 1'b0;
      inst_word  <= 32'h0;
      inst_addr  <= BASE_ADDR;
      next_addr  <= BASE_ADDR;
      err_pulse  <= 1'b0;
      err_count  <= '0;
    end else begin
      err_pulse <= 1'b0;
      next_addr <= cur_addr;
      if (inst_valid && inst_ready)
        inst_valid <= 1'b0;
      if (accept && legal) begin
        inst_valid <= 1'b1;
        inst_word  <= enc_word;
        inst_addr  <= cur_addr;
        next_addr  <= cur_addr + 32'd4;
      end else if (accept) begin
        // dropped request: address stays put, error count saturates
        err_pulse <= 1'b1;
        if (err_count != {ERR_W{1'b1}})
          err_count <= err_count + ERR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_rv_inst_encoder.sv
// Scoreboard bench for rv_inst_encoder: driver pushes expected words, a monitor pops on each output transfer.
module tb_rv_inst_encoder;

  localparam logic [31:0] BASE = 32'h0000_0000;

`ifdef ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_kind;
  logic [4:0]  req_alu_op;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm;
  logic        addr_clr;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_word;
  logic [31:0] inst_addr;
  logic        err_pulse;
  logic [7:0]  err_count;

  rv_inst_encoder #(.BASE_ADDR(BASE), .ERR_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_alu_op(req_alu_op), .req_funct3(req_funct3),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .addr_clr(addr_clr),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_word(inst_word), .inst_addr(inst_addr),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb_q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] exp_addr;
  logic [7:0]  exp_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [3:0] kind, input logic [4:0] op, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input bit legal, input logic [31:0] word,
                      input bit clr = 1'b0);
    int   n;
    bit   ok;
    exp_t e;
    req_kind = kind; req_alu_op = op; req_funct3 = f3;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    addr_clr = clr; req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    ok = req_ready;
    if (!ok) begin
      n_total++;
      $display("FAIL accept_timeout: req_ready=0 after %0d cycles, required 1", n);
    end else begin
      if (clr) exp_addr = BASE;
      if (legal) begin
        e.word = word; e.addr = exp_addr;
        sb_q.push_back(e);
        exp_addr = exp_addr + 32'd4;
      end else begin
        exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0; addr_clr = 1'b0;
    if (ok) begin
      check("err_pulse", {31'h0, err_pulse}, {31'h0, !legal});
      check("err_count", {24'h0, err_count}, {24'h0, exp_err});
    end
  endtask

  // Monitor: every negedge with valid && ready is exactly one transfer at the next posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && inst_valid && inst_ready) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected: got word %08h @%08h, required no output", inst_word, inst_addr);
        end else begin
          e = sb_q.pop_front();
          check("inst_word", inst_word, e.word);
          check("inst_addr", inst_addr, e.addr);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a_hold;
    int          n;
    rst = 1'b1; req_valid = 1'b0; req_kind = '0; req_alu_op = '0; req_funct3 = '0;
    req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0; addr_clr = 1'b0; inst_ready = 1'b1;
    exp_addr = BASE; exp_err = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'h0, inst_valid}, 32'h0);
    check("rst_word", inst_word, 32'h0);
    check("rst_addr", inst_addr, BASE);
    check("rst_err_pulse", {31'h0, err_pulse}, 32'h0);
    check("rst_err_count", {24'h0, err_count}, 32'h0);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1 rst = 1'b0;

    // legal words, back-to-back
    send(4'd0, 5'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0,        1'b1, 32'h002081B3);
    send(4'd1, 5'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF00093);
    send(4'd1, 5'd7, 3'd0, 5'd5, 5'd5, 5'd0, 32'd3,        1'b1, 32'h4032D293);
    check("no_bubble_valid", {31'h0, inst_valid}, 32'h1);
    send(4'd4, 5'd0, 3'd0, 5'd2, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h12345137);
    send(4'd7, 5'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd8,        1'b1, 32'h008000EF);
    send(4'd3, 5'd0, 3'd2, 5'd0, 5'd2, 5'd5, 32'd8,        1'b1, 32'h00512423);
    send(4'd2, 5'd0, 3'd2, 5'd6, 5'd2, 5'd0, 32'hFFFF_FFFC, 1'b1, 32'hFFC12303);
    send(4'd6, 5'd0, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 1'b1, 32'hFE208CE3);
    send(4'd8, 5'd0, 3'd0, 5'd0, 5'd1, 5'd0, 32'h0,        1'b1, 32'h00008067);
    send(4'd5, 5'd0, 3'd0, 5'd3, 5'd0, 5'd0, 32'h00001000, 1'b1, 32'h00001197);
    send(4'd0, 5'd1, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0,        1'b1, 32'h402081B3);

    // illegal kind/op/funct3: dropped, address unchanged
    send(4'd9,  5'd0,  3'd0, 5'd1, 5'd1, 5'd1, 32'h0, 1'b0, 32'h0);
    send(4'd0,  5'd10, 3'd0, 5'd1, 5'd1, 5'd1, 32'h0, 1'b0, 32'h0);
    send(4'd1,  5'd1,  3'd0, 5'd1, 5'd1, 5'd1, 32'h0, 1'b0, 32'h0);
    send(4'd2,  5'd0,  3'd3, 5'd1, 5'd1, 5'd1, 32'h0, 1'b0, 32'h0);
    send(4'd3,  5'd0,  3'd3, 5'd1, 5'd1, 5'd1, 32'h0, 1'b0, 32'h0);
    send(4'd6,  5'd0,  3'd2, 5'd1, 5'd1, 5'd1, 32'h0, 1'b0, 32'h0);
    idle(1);
    check("err_pulse_clears", {31'h0, err_pulse}, 32'h0);

    // immediate range: flagged when checking is built in, truncated otherwise
    send(4'd6, 5'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd3,    !RC, 32'h00000163);
    send(4'd1, 5'd2, 3'd0, 5'd1, 5'd1, 5'd0, 32'h23,   !RC, 32'h00309093);
    send(4'd8, 5'd0, 3'd0, 5'd0, 5'd1, 5'd0, 32'h0,    1'b1, 32'h00008067);

    // backpressure: output held, request stalls, order preserved
    idle(2);
    inst_ready = 1'b0;
    send(4'd3, 5'd0, 3'd2, 5'd0, 5'd2, 5'd5, 32'd8, 1'b1, 32'h00512423);
    a_hold = exp_addr - 32'd4;
    fork
      send(4'd0, 5'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 32'h002081B3);
      begin
        repeat (3) begin
          @(negedge clk);
          check("hold_req_ready", {31'h0, req_ready}, 32'h0);
          check("hold_word", inst_word, 32'h00512423);
          check("hold_addr", inst_addr, a_hold);
        end
        @(posedge clk); #1 inst_ready = 1'b1;
      end
    join
    send(4'd4, 5'd0, 3'd0, 5'd2, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h12345137);

    // addr_clr alone, then together with an accept at 0x10
    idle(1);
    addr_clr = 1'b1;
    idle(1);
    addr_clr = 1'b0;
    exp_addr = BASE;
    for (int i = 0; i < 4; i++)
      send(4'd8, 5'd0, 3'd0, 5'd0, 5'd1, 5'd0, 32'h0, 1'b1, 32'h00008067);
    send(4'd7, 5'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 32'h008000EF, 1'b1);
    send(4'd0, 5'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 32'h002081B3);

    // saturate the error counter
    for (int i = 0; i < 300; i++)
      send(4'd15, 5'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0);
    check("err_saturated", {24'h0, err_count}, 32'h0000_00FF);

    // reset while a word is held
    idle(2);
    inst_ready = 1'b0;
    send(4'd5, 5'd0, 3'd0, 5'd3, 5'd0, 5'd0, 32'h00001000, 1'b1, 32'h00001197);
    check("pre_rst_valid", {31'h0, inst_valid}, 32'h1);
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; inst_ready = 1'b1;
    exp_addr = BASE; exp_err = 8'd0;
    check("post_rst_valid", {31'h0, inst_valid}, 32'h0);
    check("post_rst_word", inst_word, 32'h0);
    check("post_rst_addr", inst_addr, BASE);
    check("post_rst_err_count", {24'h0, err_count}, 32'h0);
    check("post_rst_err_pulse", {31'h0, err_pulse}, 32'h0);
    send(4'd0, 5'd9, 3'd0, 5'd7, 5'd6, 5'd5, 32'h0, 1'b1, 32'h005373B3);

    n = 0;
    while (sb_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    check("sb_drained", sb_q.size(), 32'h0);
    idle(1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
